// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl: round-robin write arbiter and pointer/occupancy controller for a shared linear FIFO
//   clk_i      : clock, all state changes on posedge
//   reset_i    : synchronous active-high reset
//   wr_req_i   : per-writer push requests (level)
//   rd_req_i   : reader pop request
//   err_clr_i  : clears the sticky error flags
//   wr_gnt_o   : one-hot write grant (combinational)
//   push_o     : push strobe, equals |wr_gnt_o
//   pop_o      : pop strobe (combinational)
//   wr_ptr_o   : write address of the current push
//   rd_ptr_o   : read address of the current pop
//   count_o    : occupancy, 0..DEPTH
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
//   ovf_err_o  : sticky, push requested while full
//   unf_err_o  : sticky, pop requested while empty
module fifo_rr_ctrl #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_REQ-1:0] wr_req_i,
    input  logic             rd_req_i,
    input  logic             err_clr_i,
    output logic [N_REQ-1:0] wr_gnt_o,
    output logic             push_o,
    output logic             pop_o,
    output logic [AW-1:0]    wr_ptr_o,
    output logic [AW-1:0]    rd_ptr_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_err_o,
    output logic             unf_err_o
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [LW-1:0] last_gnt_q, last_gnt_d, gnt_idx;
    logic          ovf_q, ovf_d, unf_q, unf_d, found;
    int            idx;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;

    // Search upward from the writer after the last one granted, so the most
    // recent winner has lowest priority next time.
    always_comb begin
        gnt_idx = last_gnt_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_gnt_q) + k) % N_REQ;
            if (!found && wr_req_i[idx]) begin
                found   = 1'b1;
                gnt_idx = LW'(idx);
            end
        end
    end

    assign wr_gnt_o = (found && !full_o) ? {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx : '0;
    assign push_o   = |wr_gnt_o;
    assign pop_o    = rd_req_i & ~empty_o;

    // Power-of-two DEPTH lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d   = push_o ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_o ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + {{AW{1'b0}}, push_o} - {{AW{1'b0}}, pop_o};
        last_gnt_d = push_o ? gnt_idx : last_gnt_q;
        ovf_d      = (full_o & |wr_req_i) | (ovf_q & ~err_clr_i);
        unf_d      = (empty_o & rd_req_i) | (unf_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_gnt_q <= LW'(N_REQ - 1);
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_gnt_q <= last_gnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign wr_ptr_o  = wr_ptr_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;
    assign ovf_err_o = ovf_q;
    assign unf_err_o = unf_q;
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// tb_fifo_rr_ctrl: directed self-checking bench for fifo_rr_ctrl (N_REQ=4, DEPTH=8)
module tb_fifo_rr_ctrl;
    logic       clk = 1'b0;
    logic       reset, rd_req, err_clr;
    logic [3:0] wr_req, wr_gnt;
    logic       push, pop, full, empty, ovf_err, unf_err;
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count;
    int         tests = 0;
    int         fails = 0;

    fifo_rr_ctrl #(.N_REQ(4), .DEPTH(8)) dut (
        .clk_i(clk), .reset_i(reset), .wr_req_i(wr_req), .rd_req_i(rd_req),
        .err_clr_i(err_clr), .wr_gnt_o(wr_gnt), .push_o(push), .pop_o(pop),
        .wr_ptr_o(wr_ptr), .rd_ptr_o(rd_ptr), .count_o(count), .full_o(full),
        .empty_o(empty), .ovf_err_o(ovf_err), .unf_err_o(unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_req = '0; rd_req = 1'b0; err_clr = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_req = '0; rd_req = 1'b0; err_clr = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            wr_req = 4'($urandom);
            rd_req = 1'($urandom);
            #1;
            chk("reset_pop", pop, 0);
            cyc();
        end
        reset = 1'b0; wr_req = '0; rd_req = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_unf", unf_err, 0);

        rd_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("unf_pop", pop, 0);
            cyc();
            chk("unf_count", count, 0);
            chk("unf_flag", unf_err, 1);
        end
        err_clr = 1'b1;
        cyc();
        chk("unf_set_wins", unf_err, 1);
        rd_req = 1'b0;
        cyc();
        chk("unf_cleared", unf_err, 0);
        err_clr = 1'b0;

        do_reset();
        wr_req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_all", wr_gnt, 4'b0001 << c);
            chk("rr_push", push, 1);
            cyc();
        end
        chk("rr_count4", count, 4);
        wr_req = 4'b1010;
        #1; chk("rr_alt0", wr_gnt, 4'b0010); cyc();
        #1; chk("rr_alt1", wr_gnt, 4'b1000); cyc();
        #1; chk("rr_alt2", wr_gnt, 4'b0010); cyc();

        do_reset();
        wr_req = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            #1;
            chk("fill_gnt", wr_gnt, c <= 8 ? 4'b0001 : 4'b0000);
            cyc();
        end
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        chk("fill_wr_ptr", wr_ptr, 0);
        chk("fill_ovf", ovf_err, 1);
        rd_req = 1'b1;
        #1;
        chk("full_pp_pop", pop, 1);
        chk("full_pp_push", push, 0);
        cyc();
        chk("full_pp_count", count, 7);
        chk("full_pp_rd_ptr", rd_ptr, 1);
        chk("full_pp_full", full, 0);
        wr_req = '0; rd_req = 1'b0; err_clr = 1'b1;
        cyc();
        chk("ovf_cleared", ovf_err, 0);
        err_clr = 1'b0;

        do_reset();
        wr_req = 4'b0001;
        repeat (3) cyc();
        chk("pp3_count_pre", count, 3);
        rd_req = 1'b1;
        #1;
        chk("pp3_push", push, 1);
        chk("pp3_pop", pop, 1);
        cyc();
        chk("pp3_count", count, 3);
        chk("pp3_wr_ptr", wr_ptr, 4);
        chk("pp3_rd_ptr", rd_ptr, 1);

        do_reset();
        wr_req = 4'b0001; rd_req = 1'b1;
        #1;
        chk("pp0_push", push, 1);
        chk("pp0_pop", pop, 0);
        cyc();
        chk("pp0_count", count, 1);
        chk("pp0_rd_ptr", rd_ptr, 0);
        chk("pp0_unf", unf_err, 1);

        do_reset();
        wr_req = 4'b0100;
        repeat (7) cyc();
        wr_req = '0; rd_req = 1'b1;
        repeat (2) cyc();
        chk("mid_count", count, 5);
        chk("mid_wr_ptr", wr_ptr, 7);
        chk("mid_rd_ptr", rd_ptr, 2);
        wr_req = 4'b0100; rd_req = 1'b1; reset = 1'b1;
        cyc();
        reset = 1'b0; rd_req = 1'b0; wr_req = 4'b1111;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_wr_ptr", wr_ptr, 0);
        chk("mid_rst_rd_ptr", rd_ptr, 0);
        chk("mid_rst_empty", empty, 1);
        #1;
        chk("mid_rst_gnt", wr_gnt, 4'b0001);
        cyc();
        wr_req = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
